// File: rtl/clk_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : clk_period_meter                                         |
// | Brief    : measures period, high time and ratio lock of a slow      |
// |            asynchronous clock in units of clk cycles.               |
// |            PERIOD_METER_TOL_EN: lock compare accepts +/-1 cycle.     |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module clk_period_meter #(
  parameter int MAX_COUNT  = 1023,
  parameter int LOCK_COUNT = 4,
  localparam int CW = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          meas_clk,
  input  logic          enable,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          meas_valid,
  output logic          locked,
  output logic          overflow
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] c_max  = CW'(MAX_COUNT);
  localparam logic [MW-1:0] c_lock = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_EDGE = 2'd1,
    S_MEASURE   = 2'd2,
    S_LOCKED    = 2'd3
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [CW-1:0] r_period, w_period_next;
  logic [CW-1:0] r_high_time, w_high_time_next;
  logic [CW-1:0] r_high_pend, w_high_pend_next;
  logic          r_fall_seen, w_fall_seen_next;
  logic [MW-1:0] r_match, w_match_next, w_match_inc;
  logic          r_valid, w_valid_next;
  logic          r_locked, w_locked_next;
  logic          r_overflow, w_overflow_next;
  logic          r_sync1, r_sync2, r_sync_d;
  logic          w_rise, w_fall, w_same;

  // Chain resets high so a meas_clk already high at release is not a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= meas_clk;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync_d;
  assign w_fall = ~r_sync2 & r_sync_d;

  assign w_cnt_inc   = w_rise ? CW'(1) : ((r_cnt == c_max) ? r_cnt : r_cnt + CW'(1));
  assign w_match_inc = (r_match >= c_lock) ? c_lock : r_match + MW'(1);

`ifdef PERIOD_METER_TOL_EN
  logic [CW-1:0] w_diff;
  assign w_diff = (r_cnt >= r_period) ? (r_cnt - r_period) : (r_period - r_cnt);
  assign w_same = (w_diff <= CW'(1));
`else
  assign w_same = (r_cnt == r_period);
`endif

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_period_next    = r_period;
    w_high_time_next = r_high_time;
    w_high_pend_next = r_high_pend;
    w_fall_seen_next = r_fall_seen;
    w_match_next     = r_match;
    w_valid_next     = 1'b0;
    w_locked_next    = r_locked;
    w_overflow_next  = r_overflow;

    if (!enable) begin
      w_state_next     = S_IDLE;
      w_cnt_next       = '0;
      w_match_next     = '0;
      w_fall_seen_next = 1'b0;
      w_locked_next    = 1'b0;
      w_overflow_next  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_WAIT_EDGE;
        S_WAIT_EDGE: begin
          w_cnt_next = w_cnt_inc;
          if (w_rise) begin
            w_state_next     = S_MEASURE;
            w_fall_seen_next = 1'b0;
          end
        end
        S_MEASURE, S_LOCKED: begin
          w_cnt_next = w_cnt_inc;
          if (w_fall) begin
            w_high_pend_next = r_cnt;
            w_fall_seen_next = 1'b1;
          end
          if (w_rise) begin
            w_period_next    = r_cnt;
            // No fall since the last rise means the low pulse was lost.
            w_high_time_next = r_fall_seen ? r_high_pend : '0;
            w_fall_seen_next = 1'b0;
            w_valid_next     = 1'b1;
            if (w_same) begin
              w_match_next = w_match_inc;
              if (w_match_inc >= c_lock) begin
                w_state_next  = S_LOCKED;
                w_locked_next = 1'b1;
              end
            end else begin
              w_match_next  = MW'(1);
              w_locked_next = 1'b0;
              w_state_next  = S_MEASURE;
            end
          end else if (r_cnt == c_max) begin
            w_overflow_next  = 1'b1;
            w_locked_next    = 1'b0;
            w_match_next     = '0;
            w_fall_seen_next = 1'b0;
            w_state_next     = S_WAIT_EDGE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_high_pend <= '0;
      r_fall_seen <= 1'b0;
      r_match     <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_period    <= w_period_next;
      r_high_time <= w_high_time_next;
      r_high_pend <= w_high_pend_next;
      r_fall_seen <= w_fall_seen_next;
      r_match     <= w_match_next;
      r_valid     <= w_valid_next;
      r_locked    <= w_locked_next;
      r_overflow  <= w_overflow_next;
    end
  end

  assign period     = r_period;
  assign high_time  = r_high_time;
  assign meas_valid = r_valid;
  assign locked     = r_locked;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_clk_period_meter                                      |
// | Brief    : randomized bench for clk_period_meter against a          |
// |            timestamp-based reference model.                        |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_clk_period_meter;

  localparam int MAXC = 15;
  localparam int LOCK = 4;
  localparam int CW   = $clog2(MAXC + 1);
`ifdef PERIOD_METER_TOL_EN
  localparam int TOL = 1;
`else
  localparam int TOL = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          meas_clk;
  logic          enable;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          locked;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  clk_period_meter #(.MAX_COUNT(MAXC), .LOCK_COUNT(LOCK)) dut (
    .clk        (clk),
    .reset      (reset),
    .meas_clk   (meas_clk),
    .enable     (enable),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: edges are timestamped by clk edge index; meas_clk
  // reaches the measurement logic two sample periods late.
  int  m_mode;          // 0 idle, 1 waiting for first rise, 2 measuring
  int  k;
  int  last_rise, fall_t;
  int  e_period, e_high, e_match;
  bit  e_valid, e_locked, e_over;
  bit  h0, h1, h2;

  task automatic model_clear();
    m_mode = 0; last_rise = 0; fall_t = -1;
    e_period = 0; e_high = 0; e_match = 0;
    e_valid = 0; e_locked = 0; e_over = 0;
    h0 = 1; h1 = 1; h2 = 1;
  endtask

  task automatic model_edge();
    bit r, f;
    int el, d;
    k++;
    if (reset) begin
      model_clear();
      return;
    end
    r  = h1 & !h2;
    f  = !h1 & h2;
    h2 = h1; h1 = h0; h0 = meas_clk;
    e_valid = 0;
    if (!enable) begin
      m_mode = 0; e_locked = 0; e_over = 0; e_match = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (r) begin
        m_mode = 2; last_rise = k; fall_t = -1;
      end
    end else begin
      el = k - last_rise;
      if (f) fall_t = k;
      if (r) begin
        d = el - e_period;
        if (d < 0) d = -d;
        e_high   = (fall_t >= 0) ? (fall_t - last_rise) : 0;
        e_period = el;
        e_valid  = 1;
        e_match  = (d <= TOL) ? ((e_match < LOCK) ? e_match + 1 : LOCK) : 1;
        e_locked = (e_match >= LOCK);
        last_rise = k; fall_t = -1;
      end else if (el >= MAXC) begin
        e_over = 1; e_locked = 0; e_match = 0; m_mode = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("valid",     meas_valid, e_valid);
    check("locked",    locked,     e_locked);
    check("overflow",  overflow,   e_over);
    check("period",    period,     e_period);
    check("high_time", high_time,  e_high);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int i = 0; i < reps; i++) begin
      meas_clk = 1'b1; cycles(hi);
      meas_clk = 1'b0; cycles(lo);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, period,     0);
    check({tag, "_high"},   high_time,  0);
    check({tag, "_valid"},  meas_valid, 0);
    check({tag, "_locked"}, locked,     0);
    check({tag, "_ovf"},    overflow,   0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, reps, sel;
    k = 0;
    reset = 1'b1; enable = 1'b0; meas_clk = 1'b0;
    model_clear();
    @(negedge clk);
    check_zero("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0; enable = 1'b1;

    // divide-by-10, 50% duty
    wave(5, 5, 8);
    check("div10_locked", locked, 1);
    check("div10_period", period, 10);
    check("div10_high",   high_time, 5);

    // ratio change to divide-by-6
    wave(3, 3, 7);
    check("div6_locked", locked, 1);
    check("div6_period", period, 6);

    // stopped clock -> overflow, sticky across restart
    meas_clk = 1'b0; cycles(25);
    check("stop_ovf",    overflow, 1);
    check("stop_locked", locked, 0);
    wave(5, 5, 6);
    check("restart_ovf", overflow, 1);

    // one-cycle enable drop
    enable = 1'b0; cycles(1);
    check("endrop_locked", locked, 0);
    check("endrop_ovf",    overflow, 0);
    check("endrop_period", period, 10);
    enable = 1'b1;
    wave(5, 5, 6);

    // asynchronous reset mid high phase
    meas_clk = 1'b1; cycles(3);
    #2 reset = 1'b1;
    model_clear();
    #1 check_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    cycles(2);
    meas_clk = 1'b0; cycles(5);

    // alternating 10 / 11 periods
    for (int i = 0; i < 6; i++) begin
      wave(5, 5, 1);
      wave(5, 6, 1);
    end
    check("alt_locked", locked, (TOL == 1));

    // period exactly at saturation limit is valid; one beyond overflows
    enable = 1'b0; cycles(1); enable = 1'b1;
    wave(7, 8, 6);
    check("p15_period", period, 15);
    check("p15_ovf",    overflow, 0);
    wave(8, 8, 3);
    check("p16_ovf",    overflow, 1);

    // randomized ratios, stalls and enable glitches
    for (int s = 0; s < 24; s++) begin
      hi   = $urandom_range(2, 7);
      lo   = $urandom_range(2, 7);
      reps = $urandom_range(1, 8);
      wave(hi, lo, reps);
      sel = $urandom_range(0, 5);
      if (sel == 0) begin
        meas_clk = 1'b0; cycles($urandom_range(8, 24));
      end else if (sel == 1) begin
        enable = 1'b0; cycles($urandom_range(1, 3)); enable = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
